// File: rtl/l15_noc2_ingress_buffer.sv
// l15_noc2_ingress_buffer: NoC2-to-L1.5 flit FIFO with message tracking; define L15_NOC2_STORE_FWD_EN for store-and-forward release
module l15_noc2_ingress_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int LEN_LSB    = 22,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          noc2_router_val,
  input  logic [DATA_WIDTH-1:0]         noc2_router_data,
  output logic                          noc2_router_rdy,
  output logic                          noc2_in_val,
  output logic [DATA_WIDTH-1:0]         noc2_in_data,
  input  logic                          noc2_in_rdy,
  output logic [$clog2(DEPTH):0]        buf_occupancy,
  output logic [$clog2(DEPTH):0]        buf_msg_count,
  output logic                          buf_len_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {HDR, PAY} parse_t;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] occ, msg;
  parse_t in_st, in_st_nx, out_st, out_st_nx;
  logic [LEN_WIDTH-1:0] in_rem, in_rem_nx, out_rem, out_rem_nx, in_len, out_len;
  logic push, pop, in_tail, out_tail, len_bad;
  assign push = noc2_router_val & noc2_router_rdy;
  assign pop = noc2_in_val & noc2_in_rdy;
  assign noc2_router_rdy = occ != CW'(DEPTH);
  assign noc2_in_data = mem[rd_ptr];
  assign in_len = noc2_router_data[LEN_LSB +: LEN_WIDTH];
  assign out_len = noc2_in_data[LEN_LSB +: LEN_WIDTH];
  assign buf_occupancy = occ;
  assign buf_msg_count = msg;
`ifdef L15_NOC2_STORE_FWD_EN
  assign noc2_in_val = msg != '0;
`else
  assign noc2_in_val = occ != '0;
`endif
  // both parsers share the same rule: a header opens len payload flits, the last one is the tail
  always_comb begin
    in_tail = push & (in_st == HDR ? in_len == '0 : in_rem == LEN_WIDTH'(1));
    in_rem_nx = !push ? in_rem : in_st == HDR ? in_len : in_rem - 1'b1;
    in_st_nx = !push ? in_st : in_tail ? HDR : PAY;
    out_tail = pop & (out_st == HDR ? out_len == '0 : out_rem == LEN_WIDTH'(1));
    out_rem_nx = !pop ? out_rem : out_st == HDR ? out_len : out_rem - 1'b1;
    out_st_nx = !pop ? out_st : out_tail ? HDR : PAY;
    len_bad = push & (in_st == HDR) & (32'(in_len) + 32'd1 > 32'(DEPTH));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
      msg <= '0;
      in_st <= HDR;
      out_st <= HDR;
      in_rem <= '0;
      out_rem <= '0;
      buf_len_err <= 1'b0;
    end else begin
      if (push) mem[wr_ptr] <= noc2_router_data;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      occ <= occ + CW'(push) - CW'(pop);
      msg <= msg + CW'(in_tail) - CW'(out_tail);
      in_st <= in_st_nx;
      out_st <= out_st_nx;
      in_rem <= in_rem_nx;
      out_rem <= out_rem_nx;
      buf_len_err <= buf_len_err | len_bad;
    end
  end
endmodule

// File: tb/tb_l15_noc2_ingress_buffer.sv
// tb_l15_noc2_ingress_buffer: table vectors, directed corner sequences and random traffic against a queue model
module tb_l15_noc2_ingress_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic noc2_router_val = 1'b0, noc2_router_rdy, noc2_in_val, noc2_in_rdy = 1'b0, buf_len_err;
  logic [63:0] noc2_router_data = '0, noc2_in_data;
  logic [3:0] buf_occupancy, buf_msg_count;
  int n_cmp = 0, n_fail = 0;
  logic [63:0] q[$];
  bit tq[$];
  int need = 0;
  bit m_err = 0;

  l15_noc2_ingress_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .noc2_router_val(noc2_router_val), .noc2_router_data(noc2_router_data), .noc2_router_rdy(noc2_router_rdy),
    .noc2_in_val(noc2_in_val), .noc2_in_data(noc2_in_data), .noc2_in_rdy(noc2_in_rdy),
    .buf_occupancy(buf_occupancy), .buf_msg_count(buf_msg_count), .buf_len_err(buf_len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] hdr(input int len, input int tag);
    logic [7:0] l = 8'(len);
    logic [31:0] t = 32'(tag);
    return {t, 2'b00, l, 22'h0};
  endfunction

  function automatic int m_msg();
    int n = 0;
    foreach (tq[i]) n += int'(tq[i]);
    return n;
  endfunction

  function automatic bit m_rdy();
    return q.size() != 8;
  endfunction

  function automatic bit m_val();
`ifdef L15_NOC2_STORE_FWD_EN
    return m_msg() != 0;
`else
    return q.size() != 0;
`endif
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk(input string nm);
    cmp({nm, " rdy"}, 64'(noc2_router_rdy), 64'(m_rdy()));
    cmp({nm, " val"}, 64'(noc2_in_val), 64'(m_val()));
    cmp({nm, " occ"}, 64'(buf_occupancy), 64'(q.size()));
    cmp({nm, " msg"}, 64'(buf_msg_count), 64'(m_msg()));
    cmp({nm, " err"}, 64'(buf_len_err), 64'(m_err));
    if (q.size() != 0) cmp({nm, " data"}, noc2_in_data, q[0]);
  endtask

  task automatic model_clear();
    q.delete();
    tq.delete();
    need = 0;
    m_err = 0;
  endtask

  task automatic step(input bit v, input logic [63:0] d, input bit r, input string nm);
    bit push, pop, tail;
    int len;
    noc2_router_val = v;
    noc2_router_data = d;
    noc2_in_rdy = r;
    push = v && m_rdy();
    pop = m_val() && r;
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      void'(tq.pop_front());
    end
    if (push) begin
      len = int'(d[22 +: 8]);
      if (need == 0) begin
        if (len + 1 > 8) m_err = 1;
        tail = len == 0;
        need = len;
      end else begin
        need--;
        tail = need == 0;
      end
      q.push_back(d);
      tq.push_back(tail);
    end
    @(negedge clk);
    noc2_router_val = 1'b0;
    chk(nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    noc2_router_val = 1'b0;
    noc2_in_rdy = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v;
    logic [63:0] d;
    bit r;
    int occ;
    int msg;
    logic [63:0] head;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [63:0] h, p1, p2, p3;
    logic [63:0] seq[4];
    do_reset();
    cmp("reset occ", 64'(buf_occupancy), 0);
    cmp("reset msg", 64'(buf_msg_count), 0);
    cmp("reset val", 64'(noc2_in_val), 0);
    cmp("reset rdy", 64'(noc2_router_rdy), 1);
    cmp("reset data", noc2_in_data, 0);
    cmp("reset err", 64'(buf_len_err), 0);

    h = hdr(2, 'h11);
    p1 = 64'hA1A1_0000_0000_0001;
    p2 = 64'hA2A2_0000_0000_0002;
`ifdef L15_NOC2_STORE_FWD_EN
    tbl = '{'{1, h, 1, 1, 0, h}, '{1, p1, 1, 2, 0, h}, '{1, p2, 1, 3, 1, h},
            '{0, 0, 1, 2, 1, p1}, '{0, 0, 1, 1, 1, p2}, '{0, 0, 1, 0, 0, 0}};
`else
    tbl = '{'{1, h, 1, 1, 0, h}, '{1, p1, 1, 1, 0, p1}, '{1, p2, 1, 1, 1, p2}, '{0, 0, 1, 0, 0, 0}};
`endif
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, "t1 step");
      cmp("t1 occ", 64'(buf_occupancy), 64'(tbl[i].occ));
      cmp("t1 msg", 64'(buf_msg_count), 64'(tbl[i].msg));
      if (tbl[i].occ != 0) cmp("t1 head", noc2_in_data, tbl[i].head);
    end

    for (int i = 0; i < 8; i++) step(1, hdr(0, 'h20 + i), 0, "t2 fill");
    cmp("t2 full occ", 64'(buf_occupancy), 8);
    cmp("t2 full rdy", 64'(noc2_router_rdy), 0);
    step(1, hdr(0, 'h30), 1, "t2 pop full");
    cmp("t2 pop full occ", 64'(buf_occupancy), 7);
    step(1, hdr(0, 'h31), 1, "t2 push pop");
    cmp("t2 push pop occ", 64'(buf_occupancy), 7);
    for (int i = 0; i < 10; i++) step(0, 0, 1, "t2 drain");
    cmp("t2 drained", 64'(buf_occupancy), 0);

    h = hdr(3, 'h40);
    p1 = 64'hB1; p2 = 64'hB2; p3 = 64'hB3;
    seq = '{h, p1, p2, p3};
`ifdef L15_NOC2_STORE_FWD_EN
    step(1, h, 1, "t3 hdr");
    cmp("t3 val after hdr", 64'(noc2_in_val), 0);
    step(1, p1, 1, "t3 p1");
    step(1, p2, 1, "t3 p2");
    for (int i = 0; i < 5; i++) step(0, 0, 1, "t3 hold");
    cmp("t3 hold val", 64'(noc2_in_val), 0);
    cmp("t3 hold occ", 64'(buf_occupancy), 3);
    step(1, p3, 1, "t3 p3");
    cmp("t3 release val", 64'(noc2_in_val), 1);
    for (int i = 0; i < 4; i++) begin
      cmp("t3 stream val", 64'(noc2_in_val), 1);
      cmp("t3 stream data", noc2_in_data, seq[i]);
      step(0, 0, 1, "t3 stream");
    end
    cmp("t3 done occ", 64'(buf_occupancy), 0);
`else
    step(1, h, 1, "t4 hdr");
    cmp("t4 val after hdr", 64'(noc2_in_val), 1);
    cmp("t4 data after hdr", noc2_in_data, seq[0]);
    step(1, p1, 1, "t4 p1");
    step(1, p2, 1, "t4 p2");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, "t4 hold");
      cmp("t4 hold msg", 64'(buf_msg_count), 0);
    end
    step(1, p3, 1, "t4 p3");
    cmp("t4 tail msg", 64'(buf_msg_count), 1);
    cmp("t4 tail data", noc2_in_data, seq[3]);
    step(0, 0, 1, "t4 drain");
    cmp("t4 drained msg", 64'(buf_msg_count), 0);
`endif

    step(1, hdr(0, 'h50), 0, "t5 push");
    cmp("t5 msg", 64'(buf_msg_count), 1);
    for (int i = 0; i < 10; i++) begin
      step(1, hdr(0, 'h51 + i), 0, "t5 push");
      cmp("t5 msg up", 64'(buf_msg_count), 2);
      step(0, 0, 1, "t5 pop");
      cmp("t5 msg down", 64'(buf_msg_count), 1);
    end
    step(0, 0, 1, "t5 drain");

    for (int i = 0; i < 400; i++) begin
      logic [63:0] d = {$urandom, $urandom};
      if (need == 0 && !(q.size() == 8)) d = hdr($urandom_range(0, 5), $urandom);
      step($urandom % 4 != 0, d, $urandom % 3 != 0, "rand");
    end

    do_reset();
    step(1, hdr(8, 'h60), 0, "t6 hdr");
    cmp("t6 err set", 64'(buf_len_err), 1);
    for (int i = 0; i < 3; i++) step(1, 64'hC0 + 64'(i), 1, "t6 pay");
    cmp("t6 err sticky", 64'(buf_len_err), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("t6 rst occ", 64'(buf_occupancy), 0);
    cmp("t6 rst msg", 64'(buf_msg_count), 0);
    cmp("t6 rst val", 64'(noc2_in_val), 0);
    cmp("t6 rst rdy", 64'(noc2_router_rdy), 1);
    cmp("t6 rst data", noc2_in_data, 0);
    cmp("t6 rst err", 64'(buf_len_err), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, hdr(1, 'h70), 1, "t6 post hdr");
    step(1, 64'hD1, 1, "t6 post pay");
    step(0, 0, 1, "t6 post drain");
    step(0, 0, 1, "t6 post drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
